// File: rtl/cpu_run_ctrl.sv
// Run-control sequencer: turns monitor commands into cpu_start/quit_cmd pulses for cpu_status,
// stops on breakpoint or step exhaustion, and blocks restarts until the pipeline reset has drained.
module cpu_run_ctrl #(
    parameter int STEP_W    = 16,
    parameter int DRAIN_CYC = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_start,
    input  logic              cmd_step,
    input  logic [STEP_W-1:0] step_count,
    input  logic              cmd_quit,
    input  logic              brk_set,
    input  logic              brk_clr,
    input  logic [31:0]       brk_addr,
    input  logic              retire_valid,
    input  logic [31:0]       retire_pc,
    input  logic              stall,
    output logic              cpu_start,
    output logic              quit_cmd,
    output logic              running,
    output logic [1:0]        halt_cause,
    output logic [31:0]       instret
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STEP  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam int              DRN_W      = $clog2(DRAIN_CYC + 1);
    localparam logic [DRN_W-1:0] DRAIN_LOAD = DRN_W'(DRAIN_CYC);

    localparam logic [1:0] CAUSE_USER = 2'b00;
    localparam logic [1:0] CAUSE_BRK  = 2'b01;
    localparam logic [1:0] CAUSE_STEP = 2'b10;

    state_e            state_q, state_d;
    logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
    logic [DRN_W-1:0]  drain_cnt_q, drain_cnt_d;
    logic              brk_en_q, brk_en_d;
    logic [31:0]       brk_addr_q, brk_addr_d;
    logic              cpu_start_q, cpu_start_d;
    logic              quit_cmd_q, quit_cmd_d;
    logic              running_q, running_d;
    logic [1:0]        halt_cause_q, halt_cause_d;
    logic [31:0]       instret_q, instret_d;

    logic       ret;
    logic       active;
    logic       go;
    logic       brk_hit;
    logic       step_done;
    logic       stop;
    logic [1:0] stop_cause;

    assign ret       = retire_valid & ~stall;
    assign active    = (state_q == RUN) || (state_q == STEP);
    assign go        = (state_q == IDLE) && (cmd_start || cmd_step);
    // Compare against the breakpoint register as it stood before any same-cycle brk_set.
    assign brk_hit   = ret && brk_en_q && (retire_pc == brk_addr_q);
    assign step_done = (state_q == STEP) && ret && (step_cnt_q == STEP_W'(1));
    assign stop      = active && (cmd_quit || brk_hit || step_done);

    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
        stop_cause = CAUSE_STEP;
        if (cmd_quit) begin
            stop_cause = CAUSE_USER;
        end else if (brk_hit) begin
            stop_cause = CAUSE_BRK;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            brk_en_q     <= 1'b0;
            brk_addr_q   <= '0;
            cpu_start_q  <= 1'b0;
            quit_cmd_q   <= 1'b0;
            running_q    <= 1'b0;
            halt_cause_q <= CAUSE_USER;
            instret_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all flops update together.
            state_q      <= state_d;
            step_cnt_q   <= step_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            brk_en_q     <= brk_en_d;
            brk_addr_q   <= brk_addr_d;
            cpu_start_q  <= cpu_start_d;
            quit_cmd_q   <= quit_cmd_d;
            running_q    <= running_d;
            halt_cause_q <= halt_cause_d;
            instret_q    <= instret_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d     = state_q;
        step_cnt_d  = step_cnt_q;
        drain_cnt_d = drain_cnt_q;
        case (state_q)
            IDLE: begin
                if (cmd_step) begin
                    state_d    = STEP;
                    step_cnt_d = (step_count == '0) ? STEP_W'(1) : step_count;
                end else if (cmd_start) begin
                    state_d = RUN;
                end
            end
            RUN, STEP: begin
                if ((state_q == STEP) && ret) begin
                    step_cnt_d = step_cnt_q - STEP_W'(1);
                end
                if (stop) begin
                    state_d     = DRAIN;
                    drain_cnt_d = DRAIN_LOAD;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q - DRN_W'(1);
                if (drain_cnt_q == DRN_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and breakpoint register logic.
    always_comb begin
        cpu_start_d  = go;
        quit_cmd_d   = stop;
        running_d    = (state_d == RUN) || (state_d == STEP);
        halt_cause_d = halt_cause_q;
        instret_d    = instret_q;
        if (go) begin
            halt_cause_d = CAUSE_USER;
            instret_d    = '0;
        end else if (active) begin
            if (ret) begin
                instret_d = instret_q + 32'd1;
            end
            if (stop) begin
                halt_cause_d = stop_cause;
            end
        end

        brk_en_d   = brk_en_q;
        brk_addr_d = brk_addr_q;
        if (brk_clr) begin
            brk_en_d = 1'b0;
        end else if (brk_set) begin
            brk_en_d   = 1'b1;
            brk_addr_d = brk_addr;
        end
    end

    assign cpu_start  = cpu_start_q;
    assign quit_cmd   = quit_cmd_q;
    assign running    = running_q;
    assign halt_cause = halt_cause_q;
    assign instret    = instret_q;

endmodule
